// File: rtl/bench_grant_monitor_if.sv
// bench_grant_monitor_if: request/grant bundle plus monitor status outputs
interface bench_grant_monitor_if #(parameter int N_CH = 2);
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] grant;
  logic            error;
  logic [3:0]      err_cause;
  logic [2:0]      err_chan;
  logic [N_CH-1:0] _rt_get;
  modport master (output req, grant, input error, err_cause, err_chan, _rt_get);
  modport slave (input req, grant, output error, err_cause, err_chan, _rt_get);
endinterface

// File: rtl/bench_grant_monitor.sv
// bench_grant_monitor: sticky safety monitor for wait, budget, mutex and spurious-grant violations
module bench_grant_monitor #(
  parameter int N_CH          = 2,
  parameter int BUDGET        = 3,
  parameter int MAX_WAIT      = 1,
  parameter int REFILL_PERIOD = 8,
  parameter int STRICT        = 1,
  parameter int CNT_W         = 3
) (
  input logic clk,
  input logic rst,
  bench_grant_monitor_if.slave bus
);
  localparam int PW = REFILL_PERIOD > 1 ? $clog2(REFILL_PERIOD) : 1;
  localparam logic [PW-1:0] PLAST = REFILL_PERIOD > 0 ? PW'(REFILL_PERIOD - 1) : '0;
  localparam logic [CNT_W-1:0] MW = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] BG = CNT_W'(BUDGET);
  logic [N_CH-1:0][CNT_W-1:0] gcnt_q, gcnt_d, wcnt_q, wcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          error_q;
  logic [3:0]    cause_q;
  logic [2:0]    chan_q, chan_d, fc, fg;
  logic [N_CH-1:0] wv, bv, sv, pch;
  logic          refill, mutex, any;
  assign refill = (REFILL_PERIOD > 0) && (pcnt_q == PLAST);
  assign mutex  = |(bus.grant & (bus.grant - 1'b1));
  assign pch    = wv | bv | sv;
  assign any    = |pch | mutex;
  assign pcnt_d = refill ? '0 : pcnt_q + 1'b1;
  assign chan_d = |pch ? fc : fg;
  always_comb begin
    gcnt_d = gcnt_q;
    wcnt_d = '0;
    wv = '0;
    bv = '0;
    sv = '0;
    fc = '0;
    fg = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      wv[k] = bus.req[k] & ~bus.grant[k] & (wcnt_q[k] >= MW);
      bv[k] = gcnt_q[k] >= BG;
      sv[k] = (STRICT != 0) & bus.grant[k] & ~bus.req[k];
      gcnt_d[k] = refill ? '0 : (bus.req[k] & bus.grant[k] & (gcnt_q[k] < BG)) ? gcnt_q[k] + 1'b1 : gcnt_q[k];
      wcnt_d[k] = (bus.req[k] & ~bus.grant[k]) ? ((&wcnt_q[k]) ? wcnt_q[k] : wcnt_q[k] + 1'b1) : '0;
      fc = (wv[k] | bv[k] | sv[k]) ? 3'(k) : fc;
      fg = bus.grant[k] ? 3'(k) : fg;
    end
  end
  // err_chan records only the first violation; causes keep accumulating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q  <= '0;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      error_q <= 1'b0;
      cause_q <= '0;
      chan_q  <= '0;
    end else begin
      gcnt_q  <= gcnt_d;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
      error_q <= error_q | any;
      cause_q <= cause_q | {|sv, mutex, |bv, |wv};
      if (!error_q && any) chan_q <= chan_d;
    end
  end
  assign bus.error     = error_q;
  assign bus.err_cause = cause_q;
  assign bus.err_chan  = chan_q;
  assign bus._rt_get   = bus.req;
endmodule

// File: tb/tb_bench_grant_monitor.sv
// tb_bench_grant_monitor: directed checks on default, no-refill and short-refill monitors
module tb_bench_grant_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  bench_grant_monitor_if #(.N_CH(2)) ia ();
  bench_grant_monitor_if #(.N_CH(2)) ib ();
  bench_grant_monitor_if #(.N_CH(2)) ic ();
  bench_grant_monitor u_def (.clk(clk), .rst(rst), .bus(ia));
  bench_grant_monitor #(.REFILL_PERIOD(0)) u_nr (.clk(clk), .rst(rst), .bus(ib));
  bench_grant_monitor #(.REFILL_PERIOD(3)) u_r3 (.clk(clk), .rst(rst), .bus(ic));
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic [1:0] ar, ag, br, bg, cr, cg);
    ia.req = ar; ia.grant = ag;
    ib.req = br; ib.grant = bg;
    ic.req = cr; ic.grant = cg;
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask
  initial begin
    drive(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    #2;
    chk("rt_get_in_reset", 8'(ia._rt_get), 8'h02);
    chk("rst_error", 8'(ia.error), 8'h0);
    chk("rst_cause", 8'(ia.err_cause), 8'h0);
    chk("rst_chan", 8'(ia.err_chan), 8'h0);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step(1);
    rst = 1'b0;
    step(20);
    chk("idle_err_a", 8'(ia.error), 8'h0);
    chk("idle_cause_a", 8'(ia.err_cause), 8'h0);
    chk("idle_err_b", 8'(ib.error), 8'h0);
    chk("idle_cause_c", 8'(ic.err_cause), 8'h0);
    ia.req = 2'b01;
    step(1);
    chk("wait_edge1_err", 8'(ia.error), 8'h0);
    step(1);
    chk("wait_edge2_err", 8'(ia.error), 8'h1);
    chk("wait_cause", 8'(ia.err_cause), 8'h1);
    chk("wait_chan", 8'(ia.err_chan), 8'h0);
    drive(2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    step(1);
    chk("accum_cause", 8'(ia.err_cause), 8'h9);
    chk("chan_kept", 8'(ia.err_chan), 8'h0);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step(3);
    chk("sticky_err", 8'(ia.error), 8'h1);
    rst_pulse();
    drive(2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10);
    step(3);
    chk("budget_edge3_b", 8'(ib.error), 8'h0);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step(1);
    chk("budget_edge4_b", 8'(ib.error), 8'h1);
    chk("budget_cause_b", 8'(ib.err_cause), 8'h2);
    chk("budget_chan_b", 8'(ib.err_chan), 8'h1);
    chk("refill_edge4_c", 8'(ic.error), 8'h0);
    for (int i = 0; i < 30; i++) begin
      ic.req = (i % 3 != 2) ? 2'b10 : 2'b00;
      ic.grant = ic.req;
      step(1);
    end
    chk("refill_bursts_err_c", 8'(ic.error), 8'h0);
    chk("refill_bursts_cause_c", 8'(ic.err_cause), 8'h0);
    chk("idle_during_budget_a", 8'(ia.error), 8'h0);
    rst_pulse();
    drive(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    step(1);
    chk("mutex_err", 8'(ia.error), 8'h1);
    chk("mutex_cause", 8'(ia.err_cause), 8'h4);
    chk("mutex_chan", 8'(ia.err_chan), 8'h0);
    rst_pulse();
    drive(2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00);
    step(1);
    chk("spur_cause_a", 8'(ia.err_cause), 8'h8);
    chk("spur_chan_a", 8'(ia.err_chan), 8'h0);
    chk("spur_err_b", 8'(ib.error), 8'h1);
    chk("spur_cause_b", 8'(ib.err_cause), 8'h8);
    chk("spur_chan_b", 8'(ib.err_chan), 8'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_err", 8'(ia.error), 8'h0);
    chk("async_rst_cause", 8'(ia.err_cause), 8'h0);
    chk("async_rst_chan_b", 8'(ib.err_chan), 8'h0);
    chk("async_rst_err_b", 8'(ib.error), 8'h0);
    rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
